// File: rtl/jtag_dr_bank.sv
// JTAG data-register bank: BYPASS, IDCODE, USERCODE, RUNBIST status and a boundary-scan
// register with update stage and pad/core steering. TDO is launched on the falling TCK edge.
module jtag_dr_bank #(
    parameter int                    IR_WIDTH   = 4,
    parameter int                    ID_WIDTH   = 32,
    parameter logic [ID_WIDTH-1:0]   ID_VALUE   = 32'h1234_5679,
    parameter int                    USER_WIDTH = 32,
    parameter logic [USER_WIDTH-1:0] USER_VALUE = 32'hA1A1_A1A1,
    parameter int                    N_IO       = 4
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TLR,
    input  logic                TDI,
    input  logic                UPDATE_IR,
    input  logic [IR_WIDTH-1:0] LATCH_IR,
    input  logic                CAPTURE_DR,
    input  logic                SHIFT_DR,
    input  logic                UPDATE_DR,
    input  logic [N_IO-1:0]     PIN_IN,
    input  logic [N_IO-1:0]     CORE_OUT,
    input  logic [N_IO-1:0]     CORE_OE,
    input  logic                BIST_DONE,
    input  logic                BIST_PASS,
    output logic [N_IO-1:0]     PAD_OUT,
    output logic [N_IO-1:0]     PAD_OE,
    output logic [N_IO-1:0]     CORE_IN,
    output logic                BIST_RUN,
    output logic                TDO,
    output logic                TDO_EN
);

    localparam int BSR_WIDTH = 3 * N_IO;

    localparam logic [IR_WIDTH-1:0] OP_SAMPLE   = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] OP_EXTEST   = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] OP_INTEST   = IR_WIDTH'(3);
    localparam logic [IR_WIDTH-1:0] OP_RUNBIST  = IR_WIDTH'(4);
    localparam logic [IR_WIDTH-1:0] OP_CLAMP    = IR_WIDTH'(5);
    localparam logic [IR_WIDTH-1:0] OP_IDCODE   = IR_WIDTH'(7);
    localparam logic [IR_WIDTH-1:0] OP_USERCODE = IR_WIDTH'(8);
    localparam logic [IR_WIDTH-1:0] OP_HIGHZ    = IR_WIDTH'(9);

    localparam logic [ID_WIDTH-1:0] ID_CAPTURE = ID_VALUE | ID_WIDTH'(1);

    logic [IR_WIDTH-1:0]   instr;
    logic [ID_WIDTH-1:0]   id_reg;
    logic [USER_WIDTH-1:0] user_reg;
    logic                  bypass_reg;
    logic [1:0]            status_reg;
    logic [BSR_WIDTH-1:0]  bsr;
    logic [BSR_WIDTH-1:0]  upd;
    logic                  sel_bsr, sel_id, sel_user, sel_stat, sel_byp;
    logic                  dr_lsb;
    logic                  rst;

    assign rst = TRST | TLR;

    // Anything not explicitly decoded falls through to the 1-bit bypass register.
    always_comb begin
        sel_bsr  = (instr == OP_SAMPLE) || (instr == OP_EXTEST) || (instr == OP_INTEST);
        sel_id   = (instr == OP_IDCODE);
        sel_user = (instr == OP_USERCODE);
        sel_stat = (instr == OP_RUNBIST);
        sel_byp  = !(sel_bsr || sel_id || sel_user || sel_stat);
    end

    always_ff @(posedge TCK) begin
        if (rst) begin
            instr      <= OP_IDCODE;
            id_reg     <= ID_CAPTURE;
            user_reg   <= USER_VALUE;
            bypass_reg <= 1'b0;
            status_reg <= 2'b00;
            bsr        <= '0;
            upd        <= '0;
        end else if (UPDATE_IR) begin
            instr <= LATCH_IR;
        end else if (CAPTURE_DR) begin
            if (sel_id)   id_reg     <= ID_CAPTURE;
            if (sel_user) user_reg   <= USER_VALUE;
            if (sel_byp)  bypass_reg <= 1'b0;
            if (sel_stat) status_reg <= {BIST_PASS, BIST_DONE};
            if (instr == OP_SAMPLE) bsr <= {CORE_OE, CORE_OUT, PIN_IN};
            if (instr == OP_EXTEST) bsr[N_IO-1:0] <= PIN_IN;
            if (instr == OP_INTEST) bsr[BSR_WIDTH-1:N_IO] <= {CORE_OE, CORE_OUT};
        end else if (SHIFT_DR) begin
            if (sel_id)   id_reg     <= {TDI, id_reg[ID_WIDTH-1:1]};
            if (sel_user) user_reg   <= {TDI, user_reg[USER_WIDTH-1:1]};
            if (sel_byp)  bypass_reg <= TDI;
            if (sel_stat) status_reg <= {TDI, status_reg[1]};
            if (sel_bsr)  bsr        <= {TDI, bsr[BSR_WIDTH-1:1]};
        end else if (UPDATE_DR && sel_bsr) begin
            upd <= bsr;
        end
    end

    always_comb begin
        dr_lsb = bypass_reg;
        if (sel_bsr)  dr_lsb = bsr[0];
        if (sel_id)   dr_lsb = id_reg[0];
        if (sel_user) dr_lsb = user_reg[0];
        if (sel_stat) dr_lsb = status_reg[0];
    end

    always_ff @(negedge TCK) begin
        if (rst) begin
            TDO    <= 1'b0;
            TDO_EN <= 1'b0;
        end else begin
            TDO    <= dr_lsb;
            TDO_EN <= SHIFT_DR;
        end
    end

    always_comb begin
        PAD_OUT  = CORE_OUT;
        PAD_OE   = CORE_OE;
        CORE_IN  = PIN_IN;
        BIST_RUN = (instr == OP_RUNBIST);
        if ((instr == OP_EXTEST) || (instr == OP_CLAMP)) begin
            PAD_OUT = upd[2*N_IO-1:N_IO];
            PAD_OE  = upd[BSR_WIDTH-1:2*N_IO];
        end else if ((instr == OP_HIGHZ) || (instr == OP_INTEST)) begin
            PAD_OUT = '0;
            PAD_OE  = '0;
        end
        if (instr == OP_INTEST) CORE_IN = upd[N_IO-1:0];
    end

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Bench for jtag_dr_bank: directed scenarios plus randomized instruction/shift sequences
// checked against a bit-level reference model of the data registers and pad steering.
module tb_jtag_dr_bank;

    logic       TCK = 1'b0;
    logic       TRST = 1'b1, TLR = 1'b0, TDI = 1'b0;
    logic       UPDATE_IR = 1'b0, CAPTURE_DR = 1'b0, SHIFT_DR = 1'b0, UPDATE_DR = 1'b0;
    logic [3:0] LATCH_IR = 4'h0;
    logic [3:0] PIN_IN = 4'h0, CORE_OUT = 4'h0, CORE_OE = 4'h0;
    logic       BIST_DONE = 1'b0, BIST_PASS = 1'b0;
    logic [3:0] PAD_OUT, PAD_OE, CORE_IN;
    logic       BIST_RUN, TDO, TDO_EN;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int          m_instr;
    logic [11:0] m_bsr, m_upd;
    logic [31:0] m_dr;

    logic [63:0] got, exp, din;
    int          en;
    logic [12:0] pins;

    assign pins = {PAD_OUT, PAD_OE, CORE_IN, BIST_RUN};

    jtag_dr_bank #(
        .IR_WIDTH(4), .ID_WIDTH(32), .ID_VALUE(32'h1234_5679),
        .USER_WIDTH(32), .USER_VALUE(32'hA1A1_A1A1), .N_IO(4)
    ) dut (
        .TCK(TCK), .TRST(TRST), .TLR(TLR), .TDI(TDI),
        .UPDATE_IR(UPDATE_IR), .LATCH_IR(LATCH_IR),
        .CAPTURE_DR(CAPTURE_DR), .SHIFT_DR(SHIFT_DR), .UPDATE_DR(UPDATE_DR),
        .PIN_IN(PIN_IN), .CORE_OUT(CORE_OUT), .CORE_OE(CORE_OE),
        .BIST_DONE(BIST_DONE), .BIST_PASS(BIST_PASS),
        .PAD_OUT(PAD_OUT), .PAD_OE(PAD_OE), .CORE_IN(CORE_IN),
        .BIST_RUN(BIST_RUN), .TDO(TDO), .TDO_EN(TDO_EN)
    );

    always #5 TCK = ~TCK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit is_bsr(int op);
        return (op == 1) || (op == 2) || (op == 3);
    endfunction

    function automatic int dr_w(int op);
        case (op)
            1, 2, 3: return 12;
            4:       return 2;
            7, 8:    return 32;
            default: return 1;
        endcase
    endfunction

    function automatic logic [12:0] exp_pins();
        logic [3:0] po, pe, ci;
        po = CORE_OUT;
        pe = CORE_OE;
        ci = PIN_IN;
        if (m_instr == 2 || m_instr == 5) begin
            po = m_upd[7:4];
            pe = m_upd[11:8];
        end else if (m_instr == 9 || m_instr == 3) begin
            po = 4'h0;
            pe = 4'h0;
        end
        if (m_instr == 3) ci = m_upd[3:0];
        return {po, pe, ci, (m_instr == 4)};
    endfunction

    task automatic model_reset();
        m_instr = 7;
        m_bsr   = '0;
        m_upd   = '0;
        m_dr    = '0;
    endtask

    task automatic model_capture();
        case (m_instr)
            1: m_bsr = {CORE_OE, CORE_OUT, PIN_IN};
            2: m_bsr[3:0] = PIN_IN;
            3: m_bsr[11:4] = {CORE_OE, CORE_OUT};
            4: m_dr = {30'b0, BIST_PASS, BIST_DONE};
            7: m_dr = 32'h1234_5679 | 32'h1;
            8: m_dr = 32'hA1A1_A1A1;
            default: m_dr = '0;
        endcase
    endtask

    task automatic model_shift(input logic bit_in, output logic bit_out);
        int w;
        w = dr_w(m_instr);
        if (is_bsr(m_instr)) begin
            bit_out = m_bsr[0];
            m_bsr   = {bit_in, m_bsr[11:1]};
        end else begin
            bit_out    = m_dr[0];
            m_dr       = m_dr >> 1;
            m_dr[w-1]  = bit_in;
        end
    endtask

    task automatic cycle();
        @(negedge TCK); #1;
        @(posedge TCK); #1;
    endtask

    task automatic load_ir(input int op);
        UPDATE_IR = 1'b1;
        LATCH_IR  = 4'(op);
        cycle();
        UPDATE_IR = 1'b0;
        m_instr   = op;
    endtask

    task automatic capture();
        CAPTURE_DR = 1'b1;
        cycle();
        CAPTURE_DR = 1'b0;
        model_capture();
    endtask

    task automatic update();
        UPDATE_DR = 1'b1;
        cycle();
        UPDATE_DR = 1'b0;
        if (is_bsr(m_instr)) m_upd = m_bsr;
    endtask

    task automatic shift(input int n, input logic [63:0] d,
                         output logic [63:0] g, output logic [63:0] x, output int e_cnt);
        logic b;
        g = '0;
        x = '0;
        e_cnt = 0;
        for (int i = 0; i < n; i++) begin
            SHIFT_DR = 1'b1;
            TDI = d[i];
            @(negedge TCK); #1;
            g[i] = TDO;
            e_cnt += (TDO_EN === 1'b1) ? 1 : 0;
            @(posedge TCK); #1;
            model_shift(d[i], b);
            x[i] = b;
        end
        SHIFT_DR = 1'b0;
        TDI = 1'b0;
    endtask

    task automatic test_reset();
        TRST = 1'b1;
        PIN_IN = 4'h6; CORE_OUT = 4'h9; CORE_OE = 4'h3;
        @(posedge TCK); #1;
        @(negedge TCK); #1;
        @(posedge TCK); #1;
        TRST = 1'b0;
        model_reset();
        vectors++;
        if (pins !== {4'h9, 4'h3, 4'h6, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_pins: got %h expected %h", pins, {4'h9, 4'h3, 4'h6, 1'b0});
        end
        vectors++;
        if ({TDO, TDO_EN} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_tdo: got %b expected 00", {TDO, TDO_EN});
        end
        PIN_IN = 4'(~4'h6); CORE_OUT = 4'h1; CORE_OE = 4'hE;
        #1;
        vectors++;
        if (pins !== exp_pins()) begin
            miscompares++;
            $display("FAIL reset_follow: got %h expected %h", pins, exp_pins());
        end
    endtask

    task automatic test_idcode();
        capture();
        shift(32, {$urandom, $urandom}, got, exp, en);
        vectors++;
        if (got[31:0] !== 32'h1234_5679) begin
            miscompares++;
            $display("FAIL idcode_word: got %h expected %h", got[31:0], 32'h1234_5679);
        end
        vectors++;
        if (en !== 32) begin
            miscompares++;
            $display("FAIL idcode_tdo_en_count: got %0d expected 32", en);
        end
        @(negedge TCK); #1;
        vectors++;
        if (TDO_EN !== 1'b0) begin
            miscompares++;
            $display("FAIL idcode_tdo_en_off: got %b expected 0", TDO_EN);
        end
        @(posedge TCK); #1;
    endtask

    task automatic test_bypass();
        load_ir(12);
        capture();
        shift(5, 64'b01101, got, exp, en);
        vectors++;
        if (got[4:0] !== 5'b11010) begin
            miscompares++;
            $display("FAIL bypass_stream: got %b expected %b", got[4:0], 5'b11010);
        end
    endtask

    task automatic test_sample();
        PIN_IN = 4'h5; CORE_OUT = 4'h3; CORE_OE = 4'hC;
        load_ir(1);
        capture();
        shift(12, {$urandom, $urandom}, got, exp, en);
        vectors++;
        if (got[11:0] !== 12'hC35) begin
            miscompares++;
            $display("FAIL sample_word: got %h expected %h", got[11:0], 12'hC35);
        end
        vectors++;
        if ({PAD_OUT, PAD_OE} !== 8'h3C) begin
            miscompares++;
            $display("FAIL sample_pads: got %h expected 3c", {PAD_OUT, PAD_OE});
        end
        for (int k = 0; k < 4; k++) begin
            PIN_IN = 4'($urandom); CORE_OUT = 4'($urandom); CORE_OE = 4'($urandom);
            capture();
            shift(12, {$urandom, $urandom}, got, exp, en);
            vectors++;
            if (got[11:0] !== {CORE_OE, CORE_OUT, PIN_IN}) begin
                miscompares++;
                $display("FAIL sample_rand: got %h expected %h", got[11:0], {CORE_OE, CORE_OUT, PIN_IN});
            end
        end
    endtask

    task automatic test_extest();
        CORE_OUT = 4'h3; CORE_OE = 4'hC; PIN_IN = 4'($urandom);
        load_ir(2);
        capture();
        shift(12, 64'hFA0, got, exp, en);
        UPDATE_DR = 1'b1;
        @(negedge TCK); #1;
        vectors++;
        if ({PAD_OUT, PAD_OE} !== {m_upd[7:4], m_upd[11:8]}) begin
            miscompares++;
            $display("FAIL extest_pre_update: got %h expected %h", {PAD_OUT, PAD_OE}, {m_upd[7:4], m_upd[11:8]});
        end
        @(posedge TCK); #1;
        UPDATE_DR = 1'b0;
        m_upd = m_bsr;
        vectors++;
        if ({PAD_OUT, PAD_OE} !== 8'hAF) begin
            miscompares++;
            $display("FAIL extest_post_update: got %h expected af", {PAD_OUT, PAD_OE});
        end
        load_ir(9);
        vectors++;
        if ({PAD_OUT, PAD_OE} !== 8'h00) begin
            miscompares++;
            $display("FAIL highz_pads: got %h expected 00", {PAD_OUT, PAD_OE});
        end
        load_ir(5);
        vectors++;
        if ({PAD_OUT, PAD_OE} !== 8'hAF) begin
            miscompares++;
            $display("FAIL clamp_pads: got %h expected af", {PAD_OUT, PAD_OE});
        end
        capture();
        shift(2, 64'b01, got, exp, en);
        vectors++;
        if (got[1:0] !== 2'b10) begin
            miscompares++;
            $display("FAIL clamp_bypass: got %b expected 10", got[1:0]);
        end
    endtask

    task automatic test_intest();
        PIN_IN = 4'h2;
        load_ir(3);
        capture();
        shift(12, 64'h009, got, exp, en);
        update();
        vectors++;
        if ({CORE_IN, PAD_OE, PAD_OUT} !== 12'h900) begin
            miscompares++;
            $display("FAIL intest_steer: got %h expected 900", {CORE_IN, PAD_OE, PAD_OUT});
        end
        CORE_OUT = 4'h6; CORE_OE = 4'h1;
        capture();
        shift(12, {$urandom, $urandom}, got, exp, en);
        vectors++;
        if (got[11:0] !== 12'h169) begin
            miscompares++;
            $display("FAIL intest_capture: got %h expected 169", got[11:0]);
        end
    endtask

    task automatic test_tlr();
        logic [11:0] d;
        d = 12'($urandom) | 12'hF10;
        load_ir(2);
        capture();
        shift(12, 64'(d), got, exp, en);
        update();
        CORE_OUT = ~d[7:4]; CORE_OE = 4'($urandom); PIN_IN = 4'($urandom);
        #1;
        vectors++;
        if (pins !== exp_pins()) begin
            miscompares++;
            $display("FAIL tlr_pre: got %h expected %h", pins, exp_pins());
        end
        capture();
        shift(4, {$urandom, $urandom}, got, exp, en);
        TLR = 1'b1;
        SHIFT_DR = 1'b1;
        TDI = 1'b1;
        cycle();
        TLR = 1'b0;
        SHIFT_DR = 1'b0;
        TDI = 1'b0;
        model_reset();
        vectors++;
        if (pins !== {CORE_OUT, CORE_OE, PIN_IN, 1'b0}) begin
            miscompares++;
            $display("FAIL tlr_pads: got %h expected %h", pins, {CORE_OUT, CORE_OE, PIN_IN, 1'b0});
        end
        capture();
        shift(32, {$urandom, $urandom}, got, exp, en);
        vectors++;
        if (got[31:0] !== 32'h1234_5679) begin
            miscompares++;
            $display("FAIL tlr_instr_idcode: got %h expected 12345679", got[31:0]);
        end
        load_ir(2);
        vectors++;
        if ({PAD_OUT, PAD_OE} !== 8'h00) begin
            miscompares++;
            $display("FAIL tlr_upd_cleared: got %h expected 00", {PAD_OUT, PAD_OE});
        end
    endtask

    task automatic test_runbist();
        BIST_DONE = 1'b1; BIST_PASS = 1'b0;
        load_ir(4);
        vectors++;
        if (BIST_RUN !== 1'b1) begin
            miscompares++;
            $display("FAIL runbist_run: got %b expected 1", BIST_RUN);
        end
        capture();
        shift(2, 64'b11, got, exp, en);
        vectors++;
        if (got[1:0] !== 2'b01) begin
            miscompares++;
            $display("FAIL runbist_status: got %b expected 01", got[1:0]);
        end
    endtask

    task automatic test_priority();
        load_ir(8);
        capture();
        UPDATE_IR = 1'b1; LATCH_IR = 4'h8; SHIFT_DR = 1'b1; TDI = 1'b1;
        cycle();
        UPDATE_IR = 1'b0; SHIFT_DR = 1'b0; TDI = 1'b0;
        shift(32, {$urandom, $urandom}, got, exp, en);
        vectors++;
        if (got[31:0] !== 32'hA1A1_A1A1) begin
            miscompares++;
            $display("FAIL priority_uir_over_shift: got %h expected a1a1a1a1", got[31:0]);
        end
    endtask

    task automatic test_random();
        int ops[12] = '{1, 2, 3, 4, 5, 7, 8, 9, 15, 0, 6, 12};
        int op, n;
        for (int k = 0; k < 40; k++) begin
            op = ops[$urandom_range(0, 11)];
            PIN_IN = 4'($urandom); CORE_OUT = 4'($urandom); CORE_OE = 4'($urandom);
            BIST_DONE = 1'($urandom); BIST_PASS = 1'($urandom);
            load_ir(op);
            vectors++;
            if (pins !== exp_pins()) begin
                miscompares++;
                $display("FAIL random_pins_ir op=%0d: got %h expected %h", op, pins, exp_pins());
            end
            capture();
            n = dr_w(op) + $urandom_range(0, 3);
            din = {$urandom, $urandom};
            shift(n, din, got, exp, en);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL random_tdo op=%0d n=%0d: got %h expected %h", op, n, got, exp);
            end
            if ($urandom_range(0, 1) == 1) update();
            CORE_OUT = 4'($urandom); PIN_IN = 4'($urandom);
            #1;
            vectors++;
            if (pins !== exp_pins()) begin
                miscompares++;
                $display("FAIL random_pins_upd op=%0d: got %h expected %h", op, pins, exp_pins());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idcode();
        test_bypass();
        test_sample();
        test_extest();
        test_intest();
        test_tlr();
        test_runbist();
        test_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
